// File: rtl/alu_red_seq_if.sv
// Start/busy/done coprocessor bus for the lane-reduction unit.
// Master issues requests on start_vld; slave reports busy, done_vld and the held result.
interface alu_red_seq_if #(
  parameter int DATA_W = 16
);
  logic              start_vld;
  logic              mode_signed;
  logic              accum;
  logic              clr_acc;
  logic [DATA_W-1:0] a_dat;
  logic [DATA_W-1:0] b_dat;
  logic              busy;
  logic              done_vld;
  logic [DATA_W-1:0] red_dat;
  logic              ovf;

  modport master (
    output start_vld, mode_signed, accum, clr_acc, a_dat, b_dat,
    input  busy, done_vld, red_dat, ovf
  );

  modport slave (
    input  start_vld, mode_signed, accum, clr_acc, a_dat, b_dat,
    output busy, done_vld, red_dat, ovf
  );
endinterface

// File: rtl/alu_red_seq.sv
// Multi-cycle saturating lane-sum (one lane pair per cycle, optional accumulate); done NLANES+2 cycles after start.
// No queueing: start is only sampled in IDLE, so the requester must stall on busy.
module alu_red_seq #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  alu_red_seq_if.slave bus_if
);

  localparam int NLANES = DATA_W / LANE_W;
  localparam int SUM_W  = DATA_W + 3;
  localparam int IDX_W  = (NLANES > 1) ? $clog2(NLANES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NLANES - 1);

  localparam logic signed [SUM_W-1:0] SMAX =
    {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SMIN =
    {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] UMAX =
    {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        a_q, a_d;
  logic [DATA_W-1:0]        b_q, b_d;
  logic                     sgn_q, sgn_d;
  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic [DATA_W-1:0]        acc_q, acc_d;
  logic [DATA_W-1:0]        red_q, red_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q, done_d;

  logic [DATA_W-1:0]        sat_val;
  logic                     sat_ovf;

  function automatic logic signed [SUM_W-1:0] ext_lane(input logic [LANE_W-1:0] v,
                                                       input logic sgn);
    ext_lane = sgn ? {{(SUM_W-LANE_W){v[LANE_W-1]}}, v}
                   : {{(SUM_W-LANE_W){1'b0}}, v};
  endfunction

  function automatic logic signed [SUM_W-1:0] ext_acc(input logic [DATA_W-1:0] v,
                                                      input logic sgn);
    ext_acc = sgn ? {{(SUM_W-DATA_W){v[DATA_W-1]}}, v}
                  : {{(SUM_W-DATA_W){1'b0}}, v};
  endfunction

  // The sum is wide enough to be exact, so clamping needs only range compares.
  always_comb begin
    sat_val = sum_q[DATA_W-1:0];
    sat_ovf = 1'b0;
    if (sgn_q) begin
      if (sum_q > SMAX) begin
        sat_val = SMAX[DATA_W-1:0];
        sat_ovf = 1'b1;
      end else if (sum_q < SMIN) begin
        sat_val = SMIN[DATA_W-1:0];
        sat_ovf = 1'b1;
      end
    end else begin
      if (sum_q[SUM_W-1]) begin
        sat_val = '0;
        sat_ovf = 1'b1;
      end else if (sum_q > UMAX) begin
        sat_val = UMAX[DATA_W-1:0];
        sat_ovf = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    sum_d   = sum_q;
    acc_d   = acc_q;
    red_d   = red_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_if.clr_acc) begin
          acc_d = '0;
        end
        if (bus_if.start_vld) begin
          a_d     = bus_if.a_dat;
          b_d     = bus_if.b_dat;
          sgn_d   = bus_if.mode_signed;
          sum_d   = (bus_if.accum && !bus_if.clr_acc)
                    ? ext_acc(acc_q, bus_if.mode_signed) : '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Operands shift down so the active lane is always the bottom one.
        sum_d = sum_q + ext_lane(a_q[LANE_W-1:0], sgn_q)
                      + ext_lane(b_q[LANE_W-1:0], sgn_q);
        a_d   = a_q >> LANE_W;
        b_d   = b_q >> LANE_W;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = SAT;
        end
      end
      SAT: begin
        red_d   = sat_val;
        acc_d   = sat_val;
        ovf_d   = sat_ovf;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      sum_q   <= '0;
      acc_q   <= '0;
      red_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      sum_q   <= sum_d;
      acc_q   <= acc_d;
      red_q   <= red_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus_if.busy     = (state_q != IDLE);
  assign bus_if.done_vld = done_q;
  assign bus_if.red_dat  = red_q;
  assign bus_if.ovf      = ovf_q;

endmodule

// File: tb/tb_alu_red_seq.sv
// Directed bench for alu_red_seq: a 2-lane and a 1-lane instance share clock and reset.
module tb_alu_red_seq;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  alu_red_seq_if #(.DATA_W(16)) if0 ();
  alu_red_seq_if #(.DATA_W(16)) if1 ();

  alu_red_seq #(.DATA_W(16), .LANE_W(8)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (if0)
  );

  alu_red_seq #(.DATA_W(16), .LANE_W(16)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic clear_start();
    if0.start_vld = 1'b0;
    if1.start_vld = 1'b0;
  endtask

  task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sgn, input logic acc, input logic clr);
    if (sel == 0) begin
      if0.a_dat = a; if0.b_dat = b; if0.mode_signed = sgn;
      if0.accum = acc; if0.clr_acc = clr; if0.start_vld = 1'b1;
    end else begin
      if1.a_dat = a; if1.b_dat = b; if1.mode_signed = sgn;
      if1.accum = acc; if1.clr_acc = clr; if1.start_vld = 1'b1;
    end
  endtask

  // Returns at the falling edge inside the done cycle; lat counts cycles after the start edge.
  task automatic wait_done(input int sel, output logic [15:0] r, output logic o,
                           output int lat, output int bcnt);
    r = '0; o = 1'b0; lat = 0; bcnt = 0;
    @(negedge clk);
    clear_start();
    if0.clr_acc = 1'b0;
    if1.clr_acc = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      if ((sel == 0) ? if0.busy : if1.busy) bcnt++;
      if ((sel == 0) ? if0.done_vld : if1.done_vld) begin
        lat = i;
        r   = (sel == 0) ? if0.red_dat : if1.red_dat;
        o   = (sel == 0) ? if0.ovf : if1.ovf;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input int sel, input logic [15:0] a,
                     input logic [15:0] b, input logic sgn, input logic acc,
                     input logic clr, input logic [15:0] er, input logic eo,
                     input int elat, input bit b2b);
    logic [15:0] r;
    logic        o;
    int          lat;
    int          bc;
    if (!b2b) @(negedge clk);
    issue(sel, a, b, sgn, acc, clr);
    wait_done(sel, r, o, lat, bc);
    chk({tag, ":red"}, 32'(r), 32'(er));
    chk({tag, ":ovf"}, 32'(o), 32'(eo));
    chk({tag, ":lat"}, lat, elat);
    chk({tag, ":busy_cycles"}, bc, elat - 1);
  endtask

  initial begin
    int          dn;
    logic [15:0] r;

    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        if0.a_dat = '0; if0.b_dat = '0; if0.mode_signed = 1'b0;
        if0.accum = 1'b0; if0.clr_acc = 1'b0; if0.start_vld = 1'b0;
      end else begin
        if1.a_dat = '0; if1.b_dat = '0; if1.mode_signed = 1'b0;
        if1.accum = 1'b0; if1.clr_acc = 1'b0; if1.start_vld = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    chk("rst:busy0", 32'(if0.busy), 0);
    chk("rst:done0", 32'(if0.done_vld), 0);
    chk("rst:red0", 32'(if0.red_dat), 0);
    chk("rst:ovf0", 32'(if0.ovf), 0);
    chk("rst:busy1", 32'(if1.busy), 0);
    chk("rst:red1", 32'(if1.red_dat), 0);
    rst_n = 1'b1;

    // 2-lane instance: basic signed/unsigned sums
    run("t1", 0, 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0, 16'h000A, 1'b0, 4, 1'b0);
    @(negedge clk);
    chk("t1:single_pulse", 32'(if0.done_vld), 0);
    run("t2", 0, 16'hFF80, 16'h80FF, 1'b1, 1'b0, 1'b0, 16'hFEFE, 1'b0, 4, 1'b0);
    run("t3", 0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h03FC, 1'b0, 4, 1'b0);

    // Accumulation chain; step 4 is issued in the done cycle of step 3
    run("acc1", 0, 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0, 16'h000A, 1'b0, 4, 1'b0);
    run("acc2", 0, 16'h0102, 16'h0304, 1'b1, 1'b1, 1'b0, 16'h0014, 1'b0, 4, 1'b0);
    run("acc3", 0, 16'h0102, 16'h0304, 1'b1, 1'b1, 1'b1, 16'h000A, 1'b0, 4, 1'b0);
    run("acc4", 0, 16'h0102, 16'h0304, 1'b1, 1'b1, 1'b0, 16'h0014, 1'b0, 4, 1'b1);
    @(negedge clk);
    chk("acc4:single_pulse", 32'(if0.done_vld), 0);

    // 1-lane instance: saturation corners
    run("sat_u", 1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 3, 1'b0);
    run("sat_sp", 1, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 3, 1'b0);
    run("sat_sn", 1, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h8000, 1'b1, 3, 1'b0);

    // start while busy with different operands must be dropped
    @(negedge clk);
    issue(0, 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clear_start();
    dn = 0;
    r = '0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      if (if0.done_vld) begin
        dn++;
        r = if0.red_dat;
      end
    end
    chk("ign:red", 32'(r), 32'h000A);
    chk("ign:done_count", dn, 1);

    // Reset in the second RUN cycle; accumulator holds 000A beforehand
    @(negedge clk);
    issue(0, 16'h0102, 16'h0304, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    clear_start();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst:busy", 32'(if0.busy), 0);
    chk("arst:red", 32'(if0.red_dat), 0);
    chk("arst:ovf", 32'(if0.ovf), 0);
    chk("arst:red1", 32'(if1.red_dat), 0);
    chk("arst:ovf1", 32'(if1.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if0.done_vld) dn++;
    end
    chk("arst:no_done", dn, 0);
    run("post_rst", 0, 16'h0102, 16'h0304, 1'b1, 1'b1, 1'b0, 16'h000A, 1'b0, 4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_red_seq.md
# alu_red_seq

Parametrised, multi-cycle successor to the single-cycle RED datapath. Sums all LANE_W-bit lanes of operands A and B, one lane pair per cycle. Supports signed or unsigned lanes, optional accumulation onto the previous result, and saturation with an overflow flag. It sits beside the ALU as a start/busy/done coprocessor, so the EX stage can stall on `busy` instead of carrying a deep adder tree.

## Interface
Parameters:
- DATA_W, 16, operand/result width
- LANE_W, 8, lane width; must divide DATA_W; NLANES = DATA_W/LANE_W

Ports (the only already-decided item is one clock with asynchronous, active-low reset):
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- mode_signed  in  1  1: lanes and accumulator are two's complement; 0: unsigned
- accum  in  1  1: add the result to the stored accumulator
- clr_acc  in  1  clear the accumulator; honoured only in IDLE
- a  in  DATA_W  operand A
- b  in  DATA_W  operand B
- busy  out  1  operation in progress
- done  out  1  single-cycle completion pulse
- red  out  DATA_W  saturated result, held until the next completion
- ovf  out  1  result was saturated, held with red

## Operation
- FSM states: IDLE, RUN, SAT. Reset state is IDLE.
- IDLE:
  - start=1 latches a, b, mode_signed, accum into internal registers.
  - Loads sum = (accum && !clr_acc) ? ext(acc) : 0.
  - Sets idx=0 and goes to RUN.
  - ext() sign-extends when mode_signed=1 and zero-extends otherwise.
- IDLE with clr_acc=1: acc <= 0. When clr_acc and start are both 1, the clear wins and the new sum base is 0.
- RUN:
  - Each cycle: sum += ext(a_lat[idx*LANE_W +: LANE_W]) + ext(b_lat[idx*LANE_W +: LANE_W]).
  - Increment idx. After the idx = NLANES-1 cycle, go to SAT.
- Internal sum width is DATA_W+3 bits, signed. This is exact for every legal parameter set; no intermediate wrap is permitted.
- SAT:
  - Signed mode: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Unsigned mode: clamp to [0, 2^DATA_W-1]. A negative sum cannot occur in unsigned mode.
  - red <= clamped value; acc <= clamped value.
  - ovf <= 1 iff clamping changed the value.
  - done pulses; go to IDLE.
- start while busy=1 is ignored and not queued. Operand and mode inputs are don't-care outside the start cycle.
- red and ovf change only on a SAT exit or on reset.
- Reset values: busy=0, done=0, red=0, ovf=0, acc=0, idx=0, state=IDLE.
- rst_n low mid-operation: all of the above are cleared immediately (asynchronous). The partial result is discarded and no done pulse is issued.

## Timing
- Start sampled high in IDLE at edge E0.
- busy is high in the cycles after E0 through the SAT cycle: NLANES+1 cycles.
- red, ovf, acc update and done=1 in the cycle after SAT, i.e. NLANES+2 cycles after E0. busy is already 0 in that cycle.
- done is high for exactly one cycle.
- A start in the done cycle is accepted (back-to-back throughput of one op per NLANES+2 cycles). With accum=1 it uses the just-written acc.
- Default parameters: latency 4 cycles.

## Test plan
- DATA_W=16, LANE_W=8, signed, accum=0, a=16'h0102, b=16'h0304 -> red=16'h000A, ovf=0; done exactly 4 cycles after start; busy high 3 cycles.
- Same configuration, signed, a=16'hFF80, b=16'h80FF (lanes -128, -1, -1, -128) -> red=16'hFEFE (-258), ovf=0. Unsigned, a=b=16'hFFFF -> red=16'h03FC, ovf=0.
- Accumulate:
  - Step 1: result 16'h000A.
  - Step 2: start with accum=1 and the same operands -> 16'h0014.
  - Step 3: start with accum=1 and clr_acc=1 -> 16'h000A.
  - Step 4: start with accum=1 issued in the done cycle of step 3 -> 16'h0014.
- DATA_W=16, LANE_W=16 instance:
  - Unsigned a=16'hFFFF, b=16'h0001 -> red=16'hFFFF, ovf=1.
  - Signed a=16'h7FFF, b=16'h0001 -> red=16'h7FFF, ovf=1.
  - Signed a=16'h8000, b=16'hFFFF -> red=16'h8000, ovf=1.
- start pulsed during busy with different operands -> ignored; the original result is produced and only one done pulse occurs.
- rst_n asserted in the second RUN cycle -> busy, red, ovf, acc read 0 before the next clock edge; no done pulse; a subsequent op computes from a zero accumulator.
